lamp_seq_monitor: RTL and testbench

//  Checker and decoder for the running-lamp bus produced by the lamp sequencer.

---
 rtl/lamp_seq_monitor.sv | 165 ++++++++++++++++
 tb/tb_lamp_seq_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lamp_seq_monitor.sv
// Receive-side checker/decoder for the running-lamp bus: locks onto the one-hot sweep,
// decodes position, counts laps, flags errors. Optional ping-pong sweep: LAMP_MON_BIDIR_EN.
module lamp_seq_monitor #(
  parameter int NLAMP = 5,
  parameter int FIRST = 1,
  parameter int LAST  = 4,
  parameter int DWELL = 1,
  parameter int LAPW  = 8
) (
  input  logic             clk,
  input  logic             rset,
  input  logic [NLAMP-1:0] lamp,
  input  logic             clr_err,
  output logic [2:0]       pos,
  output logic             locked,
  output logic [LAPW-1:0]  lap_cnt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_flag,
  output logic             dir
);

  localparam int DW = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
  localparam logic [DW-1:0] DWELL_C = DW'(DWELL);
  localparam logic [2:0] FIRST_C = 3'(FIRST);
  localparam logic [2:0] LAST_C  = 3'(LAST);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  localparam logic [1:0] E_ILL   = 2'b01;
  localparam logic [1:0] E_STEP  = 2'b10;
  localparam logic [1:0] E_DWELL = 2'b11;

  logic [0:0]    state;
  logic [DW-1:0] dcnt;

  // Sample decode: index of the lit lamp and whether the pattern is a legal sweep lamp.
  logic [2:0] idx;
  logic       any_hot;
  logic       multi_hot;
  logic       legal;

  always_comb begin
    idx       = '0;
    any_hot   = 1'b0;
    multi_hot = 1'b0;
    for (int i = 0; i < NLAMP; i++) begin
      if (lamp[i]) begin
        if (any_hot) multi_hot = 1'b1;
        any_hot = 1'b1;
        idx     = 3'(i);
      end
    end
    legal = any_hot && !multi_hot && (idx >= FIRST_C) && (idx <= LAST_C);
  end

  // Next expected lamp from the registered position, plus the direction/lap effect of accepting it.
  logic [2:0] exp_pos;
  logic       nxt_dir;
  logic       lap_inc;
  logic       lock_dir;

  always_comb begin
    exp_pos  = pos + 3'd1;
    nxt_dir  = 1'b0;
    lap_inc  = 1'b0;
    lock_dir = 1'b0;
`ifdef LAMP_MON_BIDIR_EN
    if (dir) exp_pos = pos - 3'd1;
    nxt_dir = dir;
    if (exp_pos == LAST_C)       nxt_dir = 1'b1;
    else if (exp_pos == FIRST_C) nxt_dir = 1'b0;
    lap_inc  = dir && (exp_pos == FIRST_C);
    lock_dir = (idx == LAST_C);
`else
    if (pos == LAST_C) begin
      exp_pos = FIRST_C;
      lap_inc = 1'b1;
    end
`endif
  end

  // TRACK decision; dwell is checked before the step so an early change reports code 11.
  logic       ev_err;
  logic [1:0] ev_code;
  logic       ev_accept;
  logic       ev_hold;

  always_comb begin
    ev_err    = 1'b0;
    ev_code   = 2'b00;
    ev_accept = 1'b0;
    ev_hold   = 1'b0;
    if (!legal) begin
      ev_err  = 1'b1;
      ev_code = E_ILL;
    end else if (idx == pos) begin
      if (dcnt < DWELL_C) begin
        ev_hold = 1'b1;
      end else begin
        ev_err  = 1'b1;
        ev_code = E_DWELL;
      end
    end else if (dcnt < DWELL_C) begin
      ev_err  = 1'b1;
      ev_code = E_DWELL;
    end else if (idx == exp_pos) begin
      ev_accept = 1'b1;
    end else begin
      ev_err  = 1'b1;
      ev_code = E_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      state    <= IDLE;
      pos      <= '0;
      dcnt     <= '0;
      lap_cnt  <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
      err_flag <= 1'b0;
      dir      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr_err) err_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (legal) begin
            state   <= TRACK;
            pos     <= idx;
            dcnt    <= DW'(1);
            lap_cnt <= '0;
            dir     <= lock_dir;
          end
        end
        TRACK: begin
          if (ev_err) begin
            // A new error overrides a same-cycle clr_err.
            state    <= IDLE;
            pos      <= '0;
            dcnt     <= '0;
            dir      <= 1'b0;
            err      <= 1'b1;
            err_code <= ev_code;
            err_flag <= 1'b1;
          end else if (ev_hold) begin
            dcnt <= dcnt + DW'(1);
          end else if (ev_accept) begin
            pos  <= idx;
            dcnt <= DW'(1);
            dir  <= nxt_dir;
            if (lap_inc) lap_cnt <= lap_cnt + LAPW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// Directed bench for lamp_seq_monitor: a DWELL=1 instance for sweep/error/reset cases
// and a DWELL=3 instance for dwell timing. Follows LAMP_MON_BIDIR_EN if defined.
module tb_lamp_seq_monitor;

`ifdef LAMP_MON_BIDIR_EN
  localparam bit BIDIR = 1'b1;
  localparam int NXT3  = 3;
`else
  localparam bit BIDIR = 1'b0;
  localparam int NXT3  = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rset, clr_err;
  logic [4:0] lamp;
  logic [2:0] pos;
  logic       locked, err, err_flag, dir;
  logic [7:0] lap_cnt;
  logic [1:0] err_code;

  logic       rset3, clr_err3;
  logic [4:0] lamp3;
  logic [2:0] pos3;
  logic       locked3, err3, err_flag3, dir3;
  logic [7:0] lap_cnt3;
  logic [1:0] err_code3;

  lamp_seq_monitor #(.NLAMP(5), .FIRST(1), .LAST(4), .DWELL(1), .LAPW(8)) dut (
    .clk(clk), .rset(rset), .lamp(lamp), .clr_err(clr_err),
    .pos(pos), .locked(locked), .lap_cnt(lap_cnt), .err(err),
    .err_code(err_code), .err_flag(err_flag), .dir(dir)
  );

  lamp_seq_monitor #(.NLAMP(5), .FIRST(1), .LAST(4), .DWELL(3), .LAPW(8)) dut3 (
    .clk(clk), .rset(rset3), .lamp(lamp3), .clr_err(clr_err3),
    .pos(pos3), .locked(locked3), .lap_cnt(lap_cnt3), .err(err3),
    .err_code(err_code3), .err_flag(err_flag3), .dir(dir3)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] lamp_of(input int k);
    logic [4:0] one;
    one = 5'd1;
    return one << k;
  endfunction

  // Apply a sample at the falling edge, then observe 1 time unit after the rising edge.
  task automatic drive(input logic [4:0] v);
    @(negedge clk);
    lamp = v;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic [4:0] v);
    @(negedge clk);
    lamp3 = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rset = 1'b1; clr_err = 1'b0; lamp = '0;
    rset3 = 1'b1; clr_err3 = 1'b0; lamp3 = '0;

    // Reset state, even with a legal lamp present
    drive(5'b10000);
    chk("rst_pos", pos, 0);
    chk("rst_locked", locked, 0);
    chk("rst_lap", lap_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_flag", err_flag, 0);
    chk("rst_dir", dir, 0);
    rset = 1'b0;

    // Blank, multi-hot and out-of-range in IDLE: ignored, no error
    drive(5'b00000);
    chk("idle_blank_err", err, 0);
    chk("idle_blank_locked", locked, 0);
    drive(5'b01100);
    chk("idle_multi_err", err, 0);
    chk("idle_multi_locked", locked, 0);
    drive(5'b00001);
    chk("idle_oor_locked", locked, 0);
    chk("idle_oor_err", err, 0);

    // Upward sweep 1..4
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4};
    for (int k = 1; k <= 4; k++) begin
      drive(lamp_of(k));
      chk("sweep_pos", pos, exp_q.pop_front());
      chk("sweep_locked", locked, 1);
      chk("sweep_err", err, 0);
    end
    chk("dir_at_last", dir, BIDIR);

`ifdef LAMP_MON_BIDIR_EN
    exp_q = '{3'd3, 3'd2, 3'd1};
    for (int k = 3; k >= 1; k--) begin
      drive(lamp_of(k));
      chk("down_pos", pos, exp_q.pop_front());
      chk("down_err", err, 0);
      chk("down_dir", dir, (k == 1) ? 0 : 1);
    end
    chk("bidir_lap", lap_cnt, 1);
    drive(lamp_of(2));
    chk("bidir_up_err", err, 0);
    chk("bidir_up_pos", pos, 2);
`else
    drive(lamp_of(1));
    chk("wrap_pos", pos, 1);
    chk("wrap_lap", lap_cnt, 1);
    chk("wrap_err", err, 0);
    for (int k = 2; k <= 4; k++) drive(lamp_of(k));
    drive(lamp_of(3));
    chk("down_step_err", err, 1);
    chk("down_step_code", err_code, 2);
    chk("down_step_lap_hold", lap_cnt, 1);
    chk("down_step_locked", locked, 0);
`endif

    // Wrong step from pos 2, then clr_err
    drive(lamp_of(2));
    chk("relock_pos", pos, 2);
    chk("relock_lap_clr", lap_cnt, 0);
    drive(5'b10000);
    chk("step_err", err, 1);
    chk("step_code", err_code, 2);
    chk("step_flag", err_flag, 1);
    chk("step_locked", locked, 0);
    chk("step_pos", pos, 0);
    clr_err = 1'b1;
    drive(5'b00000);
    clr_err = 1'b0;
    chk("clr_flag", err_flag, 0);
    chk("clr_err_pulse", err, 0);
    chk("clr_code_hold", err_code, 2);

    // Illegal patterns while tracking
    drive(lamp_of(3));
    chk("lock3_locked", locked, 1);
    drive(5'b01100);
    chk("multi_err", err, 1);
    chk("multi_code", err_code, 1);
    chk("multi_locked", locked, 0);
    drive(5'b00000);
    chk("idle_after_err", err, 0);
    chk("code_hold", err_code, 1);
    drive(lamp_of(1));
    drive(5'b00000);
    chk("blank_err", err, 1);
    chk("blank_code", err_code, 1);
    chk("blank_flag", err_flag, 1);

    // DWELL=1: same lamp twice is a dwell error
    drive(lamp_of(2));
    drive(lamp_of(2));
    chk("dwell1_err", err, 1);
    chk("dwell1_code", err_code, 3);

    // Build lap_cnt=5 with err_flag still set, then reset mid-sweep
    drive(lamp_of(1));
    chk("lap_lock_lap", lap_cnt, 0);
    for (int n = 0; n < 5; n++) begin
`ifdef LAMP_MON_BIDIR_EN
      drive(lamp_of(2)); drive(lamp_of(3)); drive(lamp_of(4));
      drive(lamp_of(3)); drive(lamp_of(2)); drive(lamp_of(1));
`else
      drive(lamp_of(2)); drive(lamp_of(3)); drive(lamp_of(4)); drive(lamp_of(1));
`endif
    end
    chk("lap5", lap_cnt, 5);
    chk("lap5_flag", err_flag, 1);
    chk("lap5_locked", locked, 1);
    rset = 1'b1;
    drive(lamp_of(2));
    rset = 1'b0;
    chk("midrst_pos", pos, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_lap", lap_cnt, 0);
    chk("midrst_flag", err_flag, 0);
    chk("midrst_code", err_code, 0);
    chk("midrst_err", err, 0);
    chk("midrst_dir", dir, 0);

    // clr_err together with a new error: error wins
    drive(lamp_of(1));
    clr_err = 1'b1;
    drive(lamp_of(1));
    clr_err = 1'b0;
    chk("clr_vs_err_err", err, 1);
    chk("clr_vs_err_flag", err_flag, 1);
    chk("clr_vs_err_code", err_code, 3);

    // DWELL=3 instance
    drive3(5'b00000);
    rset3 = 1'b0;
    chk("d3_rst_locked", locked3, 0);
    for (int k = 1; k <= 3; k++) begin
      for (int r = 0; r < 3; r++) begin
        drive3(lamp_of(k));
        chk("d3_hold_err", err3, 0);
        chk("d3_hold_pos", pos3, k);
      end
    end
    drive3(lamp_of(4));
    drive3(lamp_of(4));
    chk("d3_short_pre", err3, 0);
    drive3(lamp_of(NXT3));
    chk("d3_short_err", err3, 1);
    chk("d3_short_code", err_code3, 3);
    chk("d3_short_locked", locked3, 0);
    for (int r = 0; r < 3; r++) begin
      drive3(lamp_of(1));
      chk("d3_relock_err", err3, 0);
    end
    chk("d3_relock_locked", locked3, 1);
    drive3(lamp_of(1));
    chk("d3_long_err", err3, 1);
    chk("d3_long_code", err_code3, 3);
    chk("d3_long_flag", err_flag3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
